dmem_arbiter: RTL and testbench

- Sequences and shares the single-port data memory (512 words, 9-bit word address) between two requesters: the core load/store port (port C) and a debug/DMA port (port D).
- Sits between the riscv top's memory-side signals (wr, rd, addr, wr_data, rd_data) and the data memory instance.
- Round-robin arbitration with a fixed-latency read pipeline, one access in flight at a time.

---
 rtl/dmem_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port data memory between the core load/store port (C) and
// a debug/DMA port (D). Round-robin arbitration, one access in flight at a
// time, fixed-latency read pipeline of MEM_LAT cycles.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   c_req/c_wr/c_addr/c_wdata  core request (held until c_gnt)
//   c_gnt                      one-cycle pulse: core access issued
//   c_rvalid/c_rdata           one-cycle read-data valid pulse / read data
//   d_*                        same set for the debug/DMA port
//   m_rd/m_wr                  memory read / write strobes
//   m_addr/m_wdata             memory address / write data
//   m_rdata                    memory read data, valid MEM_LAT cycles after m_rd
//   busy                       high whenever the FSM is not in IDLE
//
// Handshake: a requester raises req with wr/addr/wdata and holds all of them
// stable until it sees its gnt pulse; req is only sampled while the FSM sits
// in IDLE. A read returns one rvalid pulse with rdata, exactly MEM_LAT+1
// cycles after its gnt. Writes produce no rvalid.
//
// All outputs are registered: the output-decode process computes the value
// each output register takes at the next edge, so an output asserted "in
// state S" is decoded while the FSM is making the transition into S.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_rd,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    // FSM state is kept as a plain named signal so checkers can bind to it.
    state_t state;
    state_t state_nxt;

    logic       owner;      // 0 = C, 1 = D
    logic       own_wr;     // latched access type of the owner
    logic       last_d;     // last-grant pointer: 1 = D was granted last
    logic [2:0] cnt;        // read-latency countdown

    // Arbitration: D wins if it is the only requester, or if both request
    // and C was the last port granted.
    logic              any_req;
    logic              sel_d;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req   = c_req | d_req;
    assign sel_d     = d_req & (~c_req | ~last_d);
    assign sel_wr    = sel_d ? d_wr    : c_wr;
    assign sel_addr  = sel_d ? d_addr  : c_addr;
    assign sel_wdata = sel_d ? d_wdata : c_wdata;

    // Next values of the output registers.
    logic              c_gnt_n, d_gnt_n;
    logic              c_rvalid_n, d_rvalid_n;
    logic [DATA_W-1:0] c_rdata_n, d_rdata_n;
    logic              m_rd_n, m_wr_n;
    logic [ADDR_W-1:0] m_addr_n;
    logic [DATA_W-1:0] m_wdata_n;
    logic              busy_n;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = own_wr ? IDLE : WAIT;
            WAIT:    if (cnt == 3'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        c_gnt_n    = 1'b0;
        d_gnt_n    = 1'b0;
        c_rvalid_n = 1'b0;
        d_rvalid_n = 1'b0;
        m_rd_n     = 1'b0;
        m_wr_n     = 1'b0;
        // Address/data and read-data registers hold unless reloaded.
        m_addr_n   = m_addr;
        m_wdata_n  = m_wdata;
        c_rdata_n  = c_rdata;
        d_rdata_n  = d_rdata;
        busy_n     = (state_nxt != IDLE);
        unique case (state)
            IDLE: begin
                // The m_addr/m_wdata registers double as the request latch.
                if (any_req) begin
                    c_gnt_n   = ~sel_d;
                    d_gnt_n   = sel_d;
                    m_wr_n    = sel_wr;
                    m_rd_n    = ~sel_wr;
                    m_addr_n  = sel_addr;
                    m_wdata_n = sel_wdata;
                end
            end
            WAIT: begin
                // Last WAIT cycle: m_rdata is valid now; capture it for the
                // owner and raise its rvalid for the RESP cycle.
                if (cnt == 3'd1) begin
                    if (owner) begin
                        d_rdata_n  = m_rdata;
                        d_rvalid_n = 1'b1;
                    end else begin
                        c_rdata_n  = m_rdata;
                        c_rvalid_n = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            c_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
            m_rd     <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            busy     <= 1'b0;
        end else begin
            c_gnt    <= c_gnt_n;
            d_gnt    <= d_gnt_n;
            c_rvalid <= c_rvalid_n;
            d_rvalid <= d_rvalid_n;
            c_rdata  <= c_rdata_n;
            d_rdata  <= d_rdata_n;
            m_rd     <= m_rd_n;
            m_wr     <= m_wr_n;
            m_addr   <= m_addr_n;
            m_wdata  <= m_wdata_n;
            busy     <= busy_n;
        end
    end

    // ---------------- owner, pointer and latency counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            owner  <= 1'b0;
            own_wr <= 1'b0;
            last_d <= 1'b1;     // C wins the first tie after reset
            cnt    <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= sel_d;
                        own_wr <= sel_wr;
                    end
                end
                ISSUE: begin
                    last_d <= owner;
                    if (!own_wr) cnt <= LAT_INIT;
                end
                WAIT:    cnt <= cnt - 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with MEM_LAT = 2. A cycle-by-cycle vector
// table covers reset, a core read, a debug write to the top address, the
// round-robin tie sequence and a debug read. Hand-written sequences cover
// back-to-back lone reads, reset in the middle of a read and a request
// dropped in its grant cycle. The memory is modelled as a fixed read pattern
// behind a MEM_LAT-deep data pipeline.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          c_req, c_wr, d_req, d_wr;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          m_rd, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          busy;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    // ---------------- memory model ----------------
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 9'h010)      return 32'hDEADBEEF;
        else if (a == 9'h020) return 32'h12345678;
        else                  return 32'hC0DE0000 | {23'd0, a};
    endfunction

    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= m_rd ? mem_val(m_addr) : '0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata = pipe[LAT-1];

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_out();
        return {16'd0, c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
                m_rd, m_wr, m_addr, m_wdata, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [95:0]   tag;
        logic          rst;
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic [127:0]  exp;
    } vec_t;

    function automatic vec_t mk(
        input logic [95:0] tag, input logic rst,
        input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
        input logic cg, input logic cv, input logic [DW-1:0] crd,
        input logic dg, input logic dv, input logic [DW-1:0] drd,
        input logic mr, input logic mw, input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
        input logic bsy);
        vec_t v;
        v.tag = tag; v.rst = rst;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.exp = {16'd0, cg, cv, crd, dg, dv, drd, mr, mw, ma, mwd, bsy};
        return v;
    endfunction

    localparam int NV = 21;
    vec_t tbl [NV];

    localparam logic [DW-1:0] DB  = 32'hDEADBEEF;
    localparam logic [DW-1:0] A5  = 32'hA5A5A5A5;
    localparam logic [DW-1:0] W1  = 32'h11111111;
    localparam logic [DW-1:0] W2  = 32'h22222222;
    localparam logic [DW-1:0] RD2 = 32'h12345678;

    task automatic drive_idle();
        c_req = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, g, prev_g, t0, d_hits, rv_hits;
        logic [AW-1:0] la [3];

        reset = 1'b1;
        drive_idle();

        // Each row: inputs driven during cycle t, expected outputs in cycle t+1.
        //                tag          rst  cr cw ca      cd  dr dw da      dd   cg cv crd  dg dv drd  mr mw ma      mwd  busy
        tbl[0]  = mk("reset",       1, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,'0, 0,0,'0,  0,0,9'h000,'0, 0);
        tbl[1]  = mk("rd_issue",    0, 1,0,9'h010,'0, 0,0,9'h000,'0, 1,0,'0, 0,0,'0,  1,0,9'h010,'0, 1);
        tbl[2]  = mk("rd_wait1",    0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,'0, 0,0,'0,  0,0,9'h010,'0, 1);
        tbl[3]  = mk("rd_wait2",    0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,'0, 0,0,'0,  0,0,9'h010,'0, 1);
        tbl[4]  = mk("rd_resp",     0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,1,DB, 0,0,'0,  0,0,9'h010,'0, 1);
        // d_req raised during RESP must not be sampled until IDLE
        tbl[5]  = mk("rd_idle",     0, 0,0,9'h000,'0, 1,1,9'h1FF,A5, 0,0,DB, 0,0,'0,  0,0,9'h010,'0, 0);
        tbl[6]  = mk("wr_issue",    0, 0,0,9'h000,'0, 1,1,9'h1FF,A5, 0,0,DB, 1,0,'0,  0,1,9'h1FF,A5, 1);
        tbl[7]  = mk("wr_idle",     0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,DB, 0,0,'0,  0,0,9'h1FF,A5, 0);
        tbl[8]  = mk("tie_c1",      0, 1,1,9'h001,W1, 1,1,9'h002,W2, 1,0,DB, 0,0,'0,  0,1,9'h001,W1, 1);
        tbl[9]  = mk("tie_gap1",    0, 1,1,9'h001,W1, 1,1,9'h002,W2, 0,0,DB, 0,0,'0,  0,0,9'h001,W1, 0);
        tbl[10] = mk("tie_d1",      0, 1,1,9'h001,W1, 1,1,9'h002,W2, 0,0,DB, 1,0,'0,  0,1,9'h002,W2, 1);
        tbl[11] = mk("tie_gap2",    0, 1,1,9'h001,W1, 1,1,9'h002,W2, 0,0,DB, 0,0,'0,  0,0,9'h002,W2, 0);
        tbl[12] = mk("tie_c2",      0, 1,1,9'h001,W1, 1,1,9'h002,W2, 1,0,DB, 0,0,'0,  0,1,9'h001,W1, 1);
        tbl[13] = mk("tie_gap3",    0, 1,1,9'h001,W1, 1,1,9'h002,W2, 0,0,DB, 0,0,'0,  0,0,9'h001,W1, 0);
        tbl[14] = mk("tie_d2",      0, 1,1,9'h001,W1, 1,1,9'h002,W2, 0,0,DB, 1,0,'0,  0,1,9'h002,W2, 1);
        tbl[15] = mk("tie_end",     0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,DB, 0,0,'0,  0,0,9'h002,W2, 0);
        tbl[16] = mk("d_rd_issue",  0, 0,0,9'h000,'0, 1,0,9'h020,'0, 0,0,DB, 1,0,'0,  1,0,9'h020,'0, 1);
        tbl[17] = mk("d_rd_wait1",  0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,DB, 0,0,'0,  0,0,9'h020,'0, 1);
        tbl[18] = mk("d_rd_wait2",  0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,DB, 0,0,'0,  0,0,9'h020,'0, 1);
        tbl[19] = mk("d_rd_resp",   0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,DB, 0,1,RD2, 0,0,9'h020,'0, 1);
        tbl[20] = mk("d_rd_idle",   0, 0,0,9'h000,'0, 0,0,9'h000,'0, 0,0,DB, 0,0,RD2, 0,0,9'h020,'0, 0);

        tick();
        tick();

        for (int i = 0; i < NV; i++) begin
            reset   = tbl[i].rst;
            c_req   = tbl[i].cr; c_wr = tbl[i].cw; c_addr = tbl[i].ca; c_wdata = tbl[i].cd;
            d_req   = tbl[i].dr; d_wr = tbl[i].dw; d_addr = tbl[i].da; d_wdata = tbl[i].dd;
            tick();
            check($sformatf("%0s", tbl[i].tag), pack_out(), tbl[i].exp);
        end
        drive_idle();

        // ---- lone requester: three back-to-back core reads ----
        la[0] = 9'h030; la[1] = 9'h031; la[2] = 9'h032;
        d_hits = 0;
        prev_g = 0;
        c_req = 1; c_wr = 0; c_addr = la[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                tick(); n++;
                if (d_gnt) d_hits++;
            end while (!c_gnt && n < 20);
            g = cyc;
            check("lone_gnt", {127'd0, c_gnt}, 128'd1);
            check("lone_addr", {118'd0, m_rd, m_addr}, {118'd0, 1'b1, la[k]});
            if (k > 0) check("lone_gap", 128'(g - prev_g), 128'(3 + LAT));
            prev_g = g;
            if (k < 2) c_addr = la[k+1];
            else       c_req = 0;
            n = 0;
            do begin
                tick(); n++;
                if (d_gnt) d_hits++;
            end while (!c_rvalid && n < 20);
            check("lone_rv_lat", 128'(cyc - g), 128'(1 + LAT));
            check("lone_rdata", {96'd0, c_rdata}, {96'd0, mem_val(la[k])});
        end
        check("lone_no_dgnt", 128'(d_hits), 128'd0);
        tick();

        // ---- reset in the second WAIT cycle of a read ----
        c_req = 1; c_wr = 0; c_addr = 9'h010;
        tick();
        check("rst_mid_gnt", {127'd0, c_gnt}, 128'd1);
        c_req = 0;
        tick();                 // first WAIT
        tick();                 // second WAIT
        reset = 1;
        tick();
        check("rst_mid_zero", pack_out(), 128'd0);
        reset = 0;
        rv_hits = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (c_rvalid || d_rvalid) rv_hits++;
        end
        check("rst_no_rvalid", 128'(rv_hits), 128'd0);
        c_req = 1; c_wr = 1; c_addr = 9'h0AA; c_wdata = 32'h0000AAAA;
        d_req = 1; d_wr = 1; d_addr = 9'h0BB; d_wdata = 32'h0000BBBB;
        tick();
        check("rst_c_first", {126'd0, c_gnt, d_gnt}, {126'd0, 2'b10});
        drive_idle();
        tick();
        tick();

        // ---- request dropped in its grant cycle ----
        t0 = cyc;
        c_req = 1; c_wr = 0; c_addr = 9'h040;
        tick();
        check("drop_gnt", {127'd0, c_gnt}, 128'd1);
        c_req = 0;
        n = 0;
        do begin
            tick(); n++;
        end while (!c_rvalid && n < 20);
        check("drop_rv_lat", 128'(cyc - t0), 128'(2 + LAT));
        check("drop_rdata", {96'd0, c_rdata}, {96'd0, mem_val(9'h040)});
        tick();
        check("drop_idle", {124'd0, busy, m_rd, m_wr, c_rvalid}, 128'd0);
        d_req = 1; d_wr = 1; d_addr = 9'h050; d_wdata = 32'h5;
        tick();
        check("drop_next_d", {126'd0, c_gnt, d_gnt}, {126'd0, 2'b01});
        drive_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
